// File: rtl/hdpldadapt_avmm_rdfifo_mw.sv
`default_nettype none
// ============================================================================
//  Module   : hdpldadapt_avmm_rdfifo_mw
//  Brief    : Single-clock multi-word read FIFO for the AVMM read-return path.
//             One word written per cycle, 1..RDWORDS words popped per read,
//             RDWORDS consecutive entries presented in parallel. Exact
//             occupancy, drop-oldest or block-on-full writes, sticky
//             overflow/underflow flags.
//  Revision : 1.0  initial release
// ============================================================================
module hdpldadapt_avmm_rdfifo_mw #(
    parameter int DWIDTH  = 8,
    parameter int AWIDTH  = 6,
    parameter int RDWORDS = 8,
    localparam int c_NW   = $clog2(RDWORDS) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [DWIDTH-1:0]           wr_data,
    input  logic                        rd_en,
    input  logic [c_NW-1:0]             r_rd_num,
    input  logic [AWIDTH:0]             r_pempty,
    input  logic [AWIDTH:0]             r_pfull,
    input  logic                        r_stop_read,
    input  logic                        r_stop_write,
    input  logic                        sticky_clr,
    output logic [RDWORDS*DWIDTH-1:0]   rd_data,
    output logic [AWIDTH:0]             numdata,
    output logic                        empty,
    output logic                        pempty,
    output logic                        full,
    output logic                        pfull,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int              c_DEPTH = 1 << AWIDTH;
    localparam int              c_CW    = AWIDTH + 1;
    localparam logic [AWIDTH:0] c_RDW   = c_CW'(RDWORDS);
    localparam logic [AWIDTH:0] c_FULL  = c_CW'(c_DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DWIDTH-1:0] r_mem [c_DEPTH];
    logic [AWIDTH-1:0] r_wr_ptr;
    logic [AWIDTH-1:0] r_rd_ptr;
    logic [AWIDTH:0]   r_count;
    logic              r_ovf;
    logic              r_udf;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic [AWIDTH:0]   w_num_ext;
    logic [AWIDTH:0]   w_n;          // effective pop size
    logic              w_avail_ok;   // a full pop of w_n words is possible
    logic [AWIDTH:0]   w_k;          // words actually popped this cycle
    logic              w_pop;
    logic              w_full;
    logic              w_wr_acc;
    logic              w_drop;
    logic              w_refuse;
    logic              w_ovf_set;
    logic              w_udf_set;
    logic [AWIDTH:0]   w_count_next;

    assign w_num_ext = c_CW'(r_rd_num);

    // Clamp requested pop size to 1..RDWORDS and derive this cycle's pop size
    always_comb begin
        w_n = w_num_ext;
        if (w_num_ext == '0) begin
            w_n = c_CW'(1);
        end else if (w_num_ext > c_RDW) begin
            w_n = c_RDW;
        end

        w_avail_ok = (r_count >= w_n);

        w_k = '0;
        if (rd_en) begin
            if (w_avail_ok) begin
                w_k = w_n;
            end else if (!r_stop_read) begin
                w_k = r_count;       // short pop drains what is there
            end
        end
    end

    assign w_pop    = |w_k;
    assign w_full   = (r_count == c_FULL);

    // A pop in the same cycle frees room, so a write into a full FIFO is
    // only refused or turned into a drop when nothing is being popped.
    assign w_wr_acc = wr_en & (~w_full | ~r_stop_write | w_pop);
    assign w_drop   = wr_en &  w_full & ~w_pop & ~r_stop_write;
    assign w_refuse = wr_en &  w_full & ~w_pop &  r_stop_write;

    assign w_ovf_set = w_drop | w_refuse;
    assign w_udf_set = rd_en & ~w_avail_ok;     // short or refused pop

    assign w_count_next = r_count + c_CW'(w_wr_acc) - w_k - c_CW'(w_drop);

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Storage array: cleared on reset, written at the pre-increment wr_ptr
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; a drop retires the oldest entry via rd_ptr
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AWIDTH'(1);
            end
            r_rd_ptr <= r_rd_ptr + w_k[AWIDTH-1:0] + AWIDTH'(w_drop);
            r_count  <= w_count_next;
        end
    end

    // Sticky error flags; a new event wins over a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= w_ovf_set | (r_ovf & ~sticky_clr);
            r_udf <= w_udf_set | (r_udf & ~sticky_clr);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < RDWORDS; gi++) begin : g_rd_word
            logic [AWIDTH-1:0] w_idx;
            assign w_idx = r_rd_ptr + AWIDTH'(gi);
            assign rd_data[gi*DWIDTH +: DWIDTH] = r_mem[w_idx];
        end
    endgenerate

    assign numdata   = r_count;
    assign empty     = ~w_avail_ok;
    assign pempty    = (r_count <= r_pempty);
    assign full      = w_full;
    assign pfull     = (r_count >= r_pfull);
    assign overflow  = r_ovf;
    assign underflow = r_udf;

endmodule
`default_nettype wire

// File: doc/hdpldadapt_avmm_rdfifo_mw.md
# hdpldadapt_avmm_rdfifo_mw

Single-clock, parametrised multi-word read FIFO for the AVMM read-return path. Writes one DWIDTH word per cycle and pops a runtime-selectable group of 1..RDWORDS words per read, presenting RDWORDS consecutive entries in parallel. Beyond the fixed 8-word read of the dual-clock predecessor, it adds an exact occupancy count, a configurable pop size, drop-oldest overflow and sticky overflow/underflow flags. It is used where the AVMM read side and the consumer share one clock.

## Interface
- DWIDTH, 8: data word width.
- AWIDTH, 6: address width; DEPTH = 2^AWIDTH entries.
- RDWORDS, 8: parallel read words, power of 2, 1 ≤ RDWORDS ≤ DEPTH; NW = log2(RDWORDS)+1.

- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- wr_en  in  1  write request.
- wr_data  in  DWIDTH  write data.
- rd_en  in  1  pop request.
- r_rd_num  in  NW  words per pop; 0 is treated as 1, values >RDWORDS are treated as RDWORDS (effective value N).
- r_pempty  in  AWIDTH+1  partial-empty threshold.
- r_pfull  in  AWIDTH+1  partial-full threshold.
- r_stop_read  in  1  1 = block pops with fewer than N words available.
- r_stop_write  in  1  1 = block writes when full; 0 = drop oldest.
- sticky_clr  in  1  clears overflow/underflow.
- rd_data  out  RDWORDS*DWIDTH  word i at bits [i*DWIDTH +: DWIDTH] = mem[(rd_ptr+i) mod DEPTH].
- numdata  out  AWIDTH+1  occupancy, 0..DEPTH.
- empty  out  1  numdata < N (a full pop is not possible).
- pempty  out  1  numdata ≤ r_pempty.
- full  out  1  numdata == DEPTH.
- pfull  out  1  numdata ≥ r_pfull.
- overflow  out  1  sticky: a write dropped an entry or was refused.
- underflow  out  1  sticky: a pop was short or was refused.

## Operation
- State: wr_ptr and rd_ptr (AWIDTH bits, wrap mod DEPTH), count (AWIDTH+1 bits), memory, two sticky bits. All state is registered.
- Write accepted = wr_en & (~full | ~r_stop_write). mem[wr_ptr] <= wr_data; wr_ptr+1.
- Pop size k: if rd_en=0, k=0. If count ≥ N, k=N. If count < N and r_stop_read=1, k=0. If count < N and r_stop_read=0, k=count (short pop).
- rd_ptr += k. count_next = count + w − k − d, where w = write accepted and d = drop.
- Drop-oldest: full & k==0 & wr_en & ~r_stop_write → d=1, rd_ptr+1, count stays DEPTH, overflow set.
- Refused write (full & wr_en & r_stop_write & k==0) sets overflow. If k>0 the write is accepted normally (no drop).
- underflow is set on a short pop, or on a refused pop (rd_en & count<N & r_stop_read).
- Stickies clear on sticky_clr. A simultaneous set has priority over the clear.
- Status outputs are combinational from the registered count and threshold inputs. rd_data is a combinational read of the registered pointer and memory.
- Pop and write in the same cycle: pop sees the pre-write count; the write lands at the old wr_ptr.

## Timing
- Reset (rst=1 at an edge): pointers=0, count=0, memory cleared to 0, stickies=0. Therefore rd_data=0, numdata=0, empty=1, pempty=1 (for r_pempty ≥ 0), full=0, pfull=(r_pfull==0), overflow=0, underflow=0.
- rst overrides wr_en/rd_en/sticky_clr in the same cycle. Reset mid-burst discards all contents.
- Write-to-read latency is 1 cycle: a word written at edge T appears in rd_data/numdata after T.
- A pop at edge T advances rd_data to the next group after T.
- Flags change only at edges. Threshold inputs are quasi-static; a change is reflected combinationally.
- Throughput: 1 write and 1 pop per cycle, sustained.

## Test plan
- Reset, then 8 writes 0x10..0x17 with N=8: numdata=8, empty=0 after the 8th edge. One pop → rd_data before the pop = {0x17..0x10}, after the pop numdata=0, empty=1.
- DEPTH=64, 64 writes with r_stop_write=1: full=1. 65th write refused, overflow=1, numdata=64, and rd_data word0 is still the first word.
- Same fill with r_stop_write=0, 65th write 0xAA: numdata=64, word0 = the second word written, overflow=1, mem slot 0 = 0xAA.
- N=4, 3 words present, rd_en: with r_stop_read=1 → numdata stays 3, underflow=1. With r_stop_read=0 → numdata=0, underflow=1.
- Full FIFO, simultaneous write and pop with N=2: numdata=63, overflow=0. Wrap check: 200 cycles of mixed random traffic against a scoreboard, zero mismatches.
- Assert rst mid-traffic with wr_en=rd_en=1: the next cycle shows all reset values. sticky_clr with no new event clears overflow/underflow to 0.
